// File: rtl/alu_res_station_mcdb.sv
// ALU reservation station: CDB wakeup and snoop on dispatch, oldest-first issue via an age matrix.
// Define RS_CDB_BYPASS_EN to let CDB results make an entry issue in the same cycle they are broadcast.
module alu_res_station_mcdb #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int CTL_W   = 5,
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [CTL_W-1:0]             disp_ctl,
  input  logic [TAG_W-1:0]             disp_tag,
  input  logic                         disp_s1_rdy,
  input  logic                         disp_s2_rdy,
  input  logic [DATA_W-1:0]            disp_s1_val,
  input  logic [DATA_W-1:0]            disp_s2_val,
  input  logic [TAG_W-1:0]             disp_s1_tag,
  input  logic [TAG_W-1:0]             disp_s2_tag,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]    cdb_data,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [CTL_W-1:0]             iss_ctl,
  output logic [TAG_W-1:0]             iss_tag,
  output logic [DATA_W-1:0]            iss_op1,
  output logic [DATA_W-1:0]            iss_op2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  ent_valid, s1_rdy, s2_rdy;
  logic [CTL_W-1:0]  ent_ctl [DEPTH];
  logic [TAG_W-1:0]  ent_tag [DEPTH];
  logic [TAG_W-1:0]  s1_tag  [DEPTH];
  logic [TAG_W-1:0]  s2_tag  [DEPTH];
  logic [DATA_W-1:0] s1_val  [DEPTH];
  logic [DATA_W-1:0] s2_val  [DEPTH];
  // older[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0]  older   [DEPTH];

  logic [DEPTH-1:0]  s1_hit, s2_hit, elig, iss_oh, free_oh;
  logic [DATA_W-1:0] s1_cdb [DEPTH];
  logic [DATA_W-1:0] s2_cdb [DEPTH];
  logic [DATA_W-1:0] op1_now [DEPTH];
  logic [DATA_W-1:0] op2_now [DEPTH];
  logic              d1_hit, d2_hit, free_found, blocked, accept, iss_fire;
  logic [DATA_W-1:0] d1_cdb, d2_cdb;

  // Returns {hit, data}; the lowest-numbered matching port wins.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]          t,
    input logic [NUM_CDB-1:0]        v,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] data
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int p = NUM_CDB-1; p >= 0; p--)
      if (v[p] && tags[p*TAG_W +: TAG_W] == t) r = {1'b1, data[p*DATA_W +: DATA_W]};
    return r;
  endfunction

  always_comb begin
    s1_hit = '0;
    s2_hit = '0;
    s1_cdb = '{default: '0};
    s2_cdb = '{default: '0};
    for (int i = 0; i < DEPTH; i++) begin
      {s1_hit[i], s1_cdb[i]} = cdb_lookup(s1_tag[i], cdb_valid, cdb_tag, cdb_data);
      {s2_hit[i], s2_cdb[i]} = cdb_lookup(s2_tag[i], cdb_valid, cdb_tag, cdb_data);
    end
    {d1_hit, d1_cdb} = cdb_lookup(disp_s1_tag, cdb_valid, cdb_tag, cdb_data);
    {d2_hit, d2_cdb} = cdb_lookup(disp_s2_tag, cdb_valid, cdb_tag, cdb_data);
  end

  always_comb begin
    elig    = '0;
    op1_now = '{default: '0};
    op2_now = '{default: '0};
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_CDB_BYPASS_EN
      op1_now[i] = s1_rdy[i] ? s1_val[i] : s1_cdb[i];
      op2_now[i] = s2_rdy[i] ? s2_val[i] : s2_cdb[i];
      elig[i]    = ent_valid[i] && (s1_rdy[i] || s1_hit[i]) && (s2_rdy[i] || s2_hit[i]);
`else
      op1_now[i] = s1_val[i];
      op2_now[i] = s2_val[i];
      elig[i]    = ent_valid[i] && s1_rdy[i] && s2_rdy[i];
`endif
    end
  end

  always_comb begin
    iss_oh    = '0;
    blocked   = 1'b0;
    iss_valid = 1'b0;
    iss_ctl   = '0;
    iss_tag   = '0;
    iss_op1   = '0;
    iss_op2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        if (elig[j] && older[j][i]) blocked = 1'b1;
      iss_oh[i] = elig[i] && !blocked;
      if (iss_oh[i]) begin
        iss_valid = 1'b1;
        iss_ctl   = ent_ctl[i];
        iss_tag   = ent_tag[i];
        iss_op1   = op1_now[i];
        iss_op2   = op2_now[i];
      end
    end
  end

  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (!ent_valid[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
  end

  assign disp_ready = (count != FULL);
  assign accept     = disp_valid && disp_ready;
  assign iss_fire   = iss_valid && iss_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ent_valid <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && !s1_rdy[i] && s1_hit[i]) begin
          s1_rdy[i] <= 1'b1;
          s1_val[i] <= s1_cdb[i];
        end
        if (ent_valid[i] && !s2_rdy[i] && s2_hit[i]) begin
          s2_rdy[i] <= 1'b1;
          s2_val[i] <= s2_cdb[i];
        end
        if (iss_fire && iss_oh[i]) ent_valid[i] <= 1'b0;
        if (accept && free_oh[i]) begin
          ent_valid[i] <= 1'b1;
          ent_ctl[i]   <= disp_ctl;
          ent_tag[i]   <= disp_tag;
          s1_tag[i]    <= disp_s1_tag;
          s2_tag[i]    <= disp_s2_tag;
          s1_rdy[i]    <= disp_s1_rdy || d1_hit;
          s2_rdy[i]    <= disp_s2_rdy || d2_hit;
          s1_val[i]    <= disp_s1_rdy ? disp_s1_val : d1_cdb;
          s2_val[i]    <= disp_s2_rdy ? disp_s2_val : d2_cdb;
        end
        for (int j = 0; j < DEPTH; j++) begin
          if (accept && free_oh[i])      older[i][j] <= 1'b0;
          else if (accept && free_oh[j]) older[i][j] <= 1'b1;
        end
      end
      count <= count + CNT_W'(accept) - CNT_W'(iss_fire);
    end
  end

endmodule

// File: tb/tb_alu_res_station_mcdb.sv
// Bench for alu_res_station_mcdb: directed scenarios plus random traffic against an ordered-list model.
// Follows RS_CDB_BYPASS_EN in the same way as the design.
module tb_alu_res_station_mcdb;

  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int CTL_W   = 5;
  localparam int DEPTH   = 8;
  localparam int NUM_CDB = 2;
  localparam int CNT_W   = $clog2(DEPTH+1);
`ifdef RS_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk, rst, flush, disp_valid, disp_ready, disp_s1_rdy, disp_s2_rdy;
  logic [CTL_W-1:0] disp_ctl, iss_ctl;
  logic [TAG_W-1:0] disp_tag, disp_s1_tag, disp_s2_tag, iss_tag;
  logic [DATA_W-1:0] disp_s1_val, disp_s2_val, iss_op1, iss_op2;
  logic [NUM_CDB-1:0] cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic iss_valid, iss_ready;
  logic [CNT_W-1:0] count;

  alu_res_station_mcdb #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CTL_W(CTL_W), .DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ctl(disp_ctl), .disp_tag(disp_tag),
    .disp_s1_rdy(disp_s1_rdy), .disp_s2_rdy(disp_s2_rdy), .disp_s1_val(disp_s1_val), .disp_s2_val(disp_s2_val),
    .disp_s1_tag(disp_s1_tag), .disp_s2_tag(disp_s2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_ctl(iss_ctl), .iss_tag(iss_tag),
    .iss_op1(iss_op1), .iss_op2(iss_op2), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CTL_W-1:0]  ctl;
    logic [TAG_W-1:0]  tag;
    bit                r1, r2;
    logic [DATA_W-1:0] v1, v2;
    logic [TAG_W-1:0]  t1, t2;
  } op_t;

  op_t q[$];   // station contents, oldest first
  int checks = 0;
  int failures = 0;
  logic exp_valid, exp_ready;
  logic [CTL_W-1:0] exp_ctl;
  logic [TAG_W-1:0] exp_tag;
  logic [DATA_W-1:0] exp_op1, exp_op2;
  logic [CNT_W-1:0] exp_count;
  int exp_idx;
  logic [TAG_W-1:0] got[$];

  function automatic bit cdb_hit(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
    for (int p = 0; p < NUM_CDB; p++)
      if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == t) begin
        d = cdb_data[p*DATA_W +: DATA_W];
        return 1'b1;
      end
    d = '0;
    return 1'b0;
  endfunction

  task automatic predict();
    logic [DATA_W-1:0] a, b;
    bit ok1, ok2;
    #1;
    exp_valid = 1'b0; exp_ctl = '0; exp_tag = '0; exp_op1 = '0; exp_op2 = '0; exp_idx = 0;
    exp_count = CNT_W'(q.size());
    exp_ready = (q.size() < DEPTH);
    for (int i = 0; i < q.size(); i++) begin
      ok1 = q[i].r1; a = q[i].v1;
      ok2 = q[i].r2; b = q[i].v2;
      if (BYP) begin
        if (!ok1) ok1 = cdb_hit(q[i].t1, a);
        if (!ok2) ok2 = cdb_hit(q[i].t2, b);
      end
      if (ok1 && ok2 && !exp_valid) begin
        exp_valid = 1'b1; exp_idx = i;
        exp_ctl = q[i].ctl; exp_tag = q[i].tag; exp_op1 = a; exp_op2 = b;
      end
    end
  endtask

  task automatic tick();
    op_t e;
    logic [DATA_W-1:0] d;
    bit acc;
    @(posedge clk);
    acc = disp_valid && exp_ready;
    if (rst || flush) q.delete();
    else begin
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        if (!e.r1 && cdb_hit(e.t1, d)) begin e.r1 = 1'b1; e.v1 = d; end
        if (!e.r2 && cdb_hit(e.t2, d)) begin e.r2 = 1'b1; e.v2 = d; end
        q[i] = e;
      end
      if (exp_valid && iss_ready) q.delete(exp_idx);
      if (acc) begin
        e.ctl = disp_ctl; e.tag = disp_tag; e.t1 = disp_s1_tag; e.t2 = disp_s2_tag;
        e.r1 = disp_s1_rdy; e.v1 = disp_s1_val; e.r2 = disp_s2_rdy; e.v2 = disp_s2_val;
        if (!e.r1 && cdb_hit(e.t1, d)) begin e.r1 = 1'b1; e.v1 = d; end
        if (!e.r2 && cdb_hit(e.t2, d)) begin e.r2 = 1'b1; e.v2 = d; end
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    flush = 1'b0; disp_valid = 1'b0; disp_ctl = '0; disp_tag = '0;
    disp_s1_rdy = 1'b0; disp_s2_rdy = 1'b0; disp_s1_val = '0; disp_s2_val = '0;
    disp_s1_tag = '0; disp_s2_tag = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic set_cdb(input int p, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid[p] = 1'b1;
    cdb_tag[p*TAG_W +: TAG_W] = t;
    cdb_data[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic disp(input logic [CTL_W-1:0] c, input logic [TAG_W-1:0] t,
                      input logic r1, input logic [DATA_W-1:0] v1, input logic [TAG_W-1:0] t1,
                      input logic r2, input logic [DATA_W-1:0] v2, input logic [TAG_W-1:0] t2);
    disp_valid = 1'b1; disp_ctl = c; disp_tag = t;
    disp_s1_rdy = r1; disp_s1_val = v1; disp_s1_tag = t1;
    disp_s2_rdy = r2; disp_s2_val = v2; disp_s2_tag = t2;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    predict();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(5'd1, TAG_W'(i), 1'b1, 32'd9, 4'd0, 1'b1, 32'd8, 4'd0);
      predict(); tick();
    end
    apply_reset();
    clear_inputs();
    predict();
    checks++;
    if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++;
    if (disp_ready !== 1'b1) begin failures++; $display("FAIL reset_disp_ready got=%0b want=1", disp_ready); end
    checks++;
    if (iss_valid !== 1'b0) begin failures++; $display("FAIL reset_iss_valid got=%0b want=0", iss_valid); end
    checks++;
    if ({iss_ctl, iss_tag, iss_op1, iss_op2} !== '0) begin
      failures++; $display("FAIL reset_iss_data got ctl=%0d tag=%0d op1=%h op2=%h want all 0", iss_ctl, iss_tag, iss_op1, iss_op2);
    end
  endtask

  task automatic test_basic_issue();
    apply_reset();
    iss_ready = 1'b1;
    disp(5'd3, 4'd2, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    predict(); tick();
    clear_inputs();
    predict();
    checks++;
    if ({iss_valid, iss_ctl, iss_tag, iss_op1, iss_op2} !== {1'b1, 5'd3, 4'd2, 32'd5, 32'd7}) begin
      failures++; $display("FAIL basic_issue got v=%0b ctl=%0d tag=%0d op1=%h op2=%h want v=1 ctl=3 tag=2 op1=5 op2=7", iss_valid, iss_ctl, iss_tag, iss_op1, iss_op2);
    end
    tick();
    predict();
    checks++;
    if ({count, iss_valid} !== {4'd0, 1'b0}) begin
      failures++; $display("FAIL basic_drain got cnt=%0d v=%0b want cnt=0 v=0", count, iss_valid);
    end
  endtask

  task automatic test_wakeup();
    apply_reset();
    iss_ready = 1'b1;
    disp(5'd2, 4'd1, 1'b0, 32'd0, 4'd9, 1'b1, 32'h22, 4'd0);
    predict(); tick();
    clear_inputs();
    set_cdb(1, 4'd9, 32'hABCD);
    predict();
    checks++;
    if (iss_valid !== BYP || (BYP && iss_op1 !== 32'hABCD)) begin
      failures++; $display("FAIL wakeup_bcast_cycle got v=%0b op1=%h want v=%0b op1=abcd", iss_valid, iss_op1, BYP);
    end
    tick();
    clear_inputs();
    predict();
    checks++;
    if (BYP ? (count !== 4'd0 || iss_valid !== 1'b0)
            : ({iss_valid, iss_tag, iss_op1, iss_op2} !== {1'b1, 4'd1, 32'hABCD, 32'h22})) begin
      failures++; $display("FAIL wakeup_next_cycle got v=%0b tag=%0d op1=%h cnt=%0d bypass=%0b", iss_valid, iss_tag, iss_op1, count, BYP);
    end
    tick();
  endtask

  task automatic test_full();
    apply_reset();
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(5'd4, TAG_W'(i), 1'b0, 32'd0, 4'd15, 1'b1, 32'(i * 3), 4'd0);
      predict(); tick();
    end
    disp(5'd4, 4'd9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
    predict();
    checks++;
    if ({count, disp_ready, iss_valid} !== {4'd8, 1'b0, 1'b0}) begin
      failures++; $display("FAIL full_state got cnt=%0d rdy=%0b v=%0b want cnt=8 rdy=0 v=0", count, disp_ready, iss_valid);
    end
    tick();
    clear_inputs();
    predict();
    checks++;
    if (count !== 4'd8) begin failures++; $display("FAIL full_ignore_9th got cnt=%0d want 8", count); end
    got.delete();
    iss_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      clear_inputs();
      if (c == 0) set_cdb(0, 4'd15, 32'h55);
      predict();
      checks++;
      if ({iss_valid, iss_ctl, iss_tag, iss_op1, iss_op2, count, disp_ready} !== {exp_valid, exp_ctl, exp_tag, exp_op1, exp_op2, exp_count, exp_ready}) begin
        failures++; $display("FAIL full_model c=%0d got v=%0b tag=%0d op1=%h op2=%h cnt=%0d want v=%0b tag=%0d op1=%h op2=%h cnt=%0d", c, iss_valid, iss_tag, iss_op1, iss_op2, count, exp_valid, exp_tag, exp_op1, exp_op2, exp_count);
      end
      if (iss_valid === 1'b1) got.push_back(iss_tag);
      tick();
    end
    checks++;
    if (got.size() != DEPTH) begin failures++; $display("FAIL full_issue_count got=%0d want=%0d", got.size(), DEPTH); end
    for (int k = 0; k < got.size() && k < DEPTH; k++) begin
      checks++;
      if (got[k] !== TAG_W'(k)) begin failures++; $display("FAIL full_order k=%0d got tag=%0d want=%0d", k, got[k], k); end
    end
  endtask

  task automatic test_age();
    logic [TAG_W-1:0] want [2];
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset();
      iss_ready = 1'b1;
      disp(5'd6, 4'd4, 1'b0, 32'd0, 4'd10, 1'b1, 32'h40, 4'd0);
      predict(); tick();
      disp(5'd7, 4'd5, 1'b0, 32'd0, 4'd11, 1'b1, 32'h50, 4'd0);
      predict(); tick();
      got.delete();
      for (int c = 0; c < 6; c++) begin
        clear_inputs();
        if (pass == 0 && c == 0) set_cdb(0, 4'd11, 32'h111);
        if (pass == 0 && c == 2) set_cdb(1, 4'd10, 32'h100);
        if (pass == 1 && c == 0) begin set_cdb(0, 4'd11, 32'h111); set_cdb(1, 4'd10, 32'h100); end
        predict();
        checks++;
        if ({iss_valid, iss_ctl, iss_tag, iss_op1, iss_op2, count, disp_ready} !== {exp_valid, exp_ctl, exp_tag, exp_op1, exp_op2, exp_count, exp_ready}) begin
          failures++; $display("FAIL age_model p=%0d c=%0d got v=%0b tag=%0d op1=%h cnt=%0d want v=%0b tag=%0d op1=%h cnt=%0d", pass, c, iss_valid, iss_tag, iss_op1, count, exp_valid, exp_tag, exp_op1, exp_count);
        end
        if (iss_valid === 1'b1) got.push_back(iss_tag);
        tick();
      end
      want[0] = (pass == 0) ? 4'd5 : 4'd4;
      want[1] = (pass == 0) ? 4'd4 : 4'd5;
      checks++;
      if (got.size() != 2 || got[0] !== want[0] || got[1] !== want[1]) begin
        failures++; $display("FAIL age_order p=%0d got n=%0d first=%0d want %0d then %0d", pass, got.size(), (got.size() > 0) ? got[0] : 4'd0, want[0], want[1]);
      end
    end
  endtask

  task automatic test_dispatch_snoop();
    apply_reset();
    iss_ready = 1'b1;
    disp(5'd8, 4'd3, 1'b1, 32'h1, 4'd0, 1'b0, 32'd0, 4'd6);
    set_cdb(0, 4'd6, 32'h11);
    set_cdb(1, 4'd6, 32'h99);
    predict(); tick();
    clear_inputs();
    predict();
    checks++;
    if ({iss_valid, iss_tag, iss_op1, iss_op2} !== {1'b1, 4'd3, 32'h1, 32'h11}) begin
      failures++; $display("FAIL dispatch_snoop got v=%0b tag=%0d op1=%h op2=%h want v=1 tag=3 op1=1 op2=11", iss_valid, iss_tag, iss_op1, iss_op2);
    end
    tick();
  endtask

  task automatic test_flush();
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset();
      iss_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        disp(5'd9, TAG_W'(i), 1'b0, 32'd0, 4'd12, 1'b1, 32'd3, 4'd0);
        predict(); tick();
      end
      disp(5'd9, 4'd7, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
      set_cdb(0, 4'd12, 32'h77);
      iss_ready = 1'b1;
      if (pass == 0) flush = 1'b1; else rst = 1'b1;
      predict(); tick();
      rst = 1'b0;
      clear_inputs();
      predict();
      checks++;
      if ({count, iss_valid, disp_ready} !== {4'd0, 1'b0, 1'b1}) begin
        failures++; $display("FAIL flush_clear p=%0d got cnt=%0d v=%0b rdy=%0b want cnt=0 v=0 rdy=1", pass, count, iss_valid, disp_ready);
      end
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      clear_inputs();
      if ($urandom_range(0, 9) < 6)
        disp(CTL_W'($urandom), TAG_W'($urandom), $urandom_range(0, 1) == 1, $urandom, TAG_W'($urandom_range(0, 7)),
             $urandom_range(0, 1) == 1, $urandom, TAG_W'($urandom_range(0, 7)));
      for (int p = 0; p < NUM_CDB; p++)
        if ($urandom_range(0, 9) < 4) set_cdb(p, TAG_W'($urandom_range(0, 7)), $urandom);
      iss_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 99) < 2;
      predict();
      checks++;
      if ({iss_valid, iss_ctl, iss_tag, iss_op1, iss_op2, count, disp_ready} !== {exp_valid, exp_ctl, exp_tag, exp_op1, exp_op2, exp_count, exp_ready}) begin
        failures++; $display("FAIL random_model c=%0d got v=%0b ctl=%0d tag=%0d op1=%h op2=%h cnt=%0d rdy=%0b want v=%0b ctl=%0d tag=%0d op1=%h op2=%h cnt=%0d rdy=%0b", c, iss_valid, iss_ctl, iss_tag, iss_op1, iss_op2, count, disp_ready, exp_valid, exp_ctl, exp_tag, exp_op1, exp_op2, exp_count, exp_ready);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    iss_ready = 1'b0;
    clear_inputs();
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_full();
    test_age();
    test_dispatch_snoop();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
